// File: rtl/riscv_instr_mem_responder.sv
// rtl/riscv_instr_mem_responder.sv - instruction-fetch memory responder with fixed latency and grant stalls
module riscv_instr_mem_responder #(
    parameter int          DEPTH_WORDS     = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          LATENCY         = 1,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           instr_req_i,
    input  logic [31:0]                    instr_addr_i,
    output logic                           instr_gnt_o,
    output logic                           instr_rvalid_o,
    output logic [31:0]                    instr_rdata_o,
    output logic                           instr_err_o,
    input  logic                           stall_i,
    input  logic                           load_we_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr_i,
    input  logic [31:0]                    load_wdata_i,
    output logic                           busy_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]   mem [DEPTH_WORDS];

    logic [31:0]   offset;
    logic [29:0]   idx;
    logic          in_range;
    logic [31:0]   rd_word;
    logic          unused_addr_bits;

    logic          pipe_valid [LATENCY];
    logic          pipe_err   [LATENCY];
    logic [31:0]   pipe_data  [LATENCY];

    logic [CW-1:0] outstanding;
    logic [CW-1:0] out_after_retire;
    logic          retiring;

    // Decode is relative to BASE_ADDR; addresses below the base wrap to huge offsets.
    assign offset           = instr_addr_i - BASE_ADDR;
    assign idx              = offset[31:2];
    assign unused_addr_bits = ^offset[1:0];
    assign in_range         = (instr_addr_i >= BASE_ADDR) && ({2'b00, idx} < 32'(DEPTH_WORDS));
    assign rd_word          = in_range ? mem[idx[AW-1:0]] : 32'h0;

    assign retiring         = pipe_valid[LATENCY-1];
    assign out_after_retire = outstanding - CW'(retiring);

    assign instr_gnt_o = instr_req_i & ~stall_i & ~load_we_i & ~rst
                       & (out_after_retire < CW'(MAX_OUTSTANDING));

    assign instr_rvalid_o = pipe_valid[LATENCY-1];
    assign instr_err_o    = pipe_err[LATENCY-1];
    assign instr_rdata_o  = pipe_data[LATENCY-1];
    assign busy_o         = (outstanding != '0);

    // Array is not reset so preloaded code survives a core reset.
    always_ff @(posedge clk) begin
        if (load_we_i) begin
            mem[load_addr_i] <= load_wdata_i;
        end
    end

    // Idle stages hold zeros so rdata/err read 0 whenever rvalid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_err[i]   <= 1'b0;
                pipe_data[i]  <= 32'h0;
            end
        end else begin
            pipe_valid[0] <= instr_gnt_o;
            pipe_err[0]   <= instr_gnt_o & ~in_range;
            pipe_data[0]  <= instr_gnt_o ? rd_word : 32'h0;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            outstanding <= out_after_retire + CW'(instr_gnt_o);
        end
    end

    int unsigned sva_gnt_cnt;
    int unsigned sva_rv_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sva_gnt_cnt <= 0;
            sva_rv_cnt  <= 0;
        end else begin
            sva_gnt_cnt <= sva_gnt_cnt + 32'(instr_gnt_o);
            sva_rv_cnt  <= sva_rv_cnt + 32'(instr_rvalid_o);
        end
    end

    a_gnt_needs_req : assert property (@(posedge clk) instr_gnt_o |-> instr_req_i);
    a_rv_le_gnt     : assert property (@(posedge clk) disable iff (rst) sva_rv_cnt <= sva_gnt_cnt);
    a_out_bound     : assert property (@(posedge clk) 32'(outstanding) <= MAX_OUTSTANDING);

endmodule
